// File: rtl/data_path_pkg.sv
// Shared definitions for the phase-1 single-bus datapath: ALU opcodes and bus-source encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_path_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int NUM_GPR = 16;

    // Which class of register currently drives the shared bus
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_GPR,
        SRC_HI,
        SRC_LO,
        SRC_ZHI,
        SRC_ZLO,
        SRC_MDR,
        SRC_PC
    } bus_src_e;

    // Resolved bus driver; gpr is only meaningful when src == SRC_GPR
    typedef struct packed {
        bus_src_e   src;
        logic [3:0] gpr;
    } bus_sel_t;

endpackage

// File: rtl/data_path_if.sv
// Control strobes and memory data feeding the datapath from the (future) control unit.
// Latency: n/a (wiring only).
// Backpressure: none; every strobe is obeyed in the cycle it is asserted.
interface data_path_if;

    logic        read;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        hi_in;
    logic        lo_in;
    logic        y_in;
    logic        z_in;
    logic        mdr_in;
    logic        mar_in;
    logic        pc_in;
    logic        ir_in;
    logic        hi_out;
    logic        lo_out;
    logic        zhigh_out;
    logic        zlow_out;
    logic        mdr_out;
    logic        pc_out;
    logic        inc_pc;
    logic [31:0] mdatain;
    logic [4:0]  opcode;

    modport master (
        output read, r_in, r_out, hi_in, lo_in, y_in, z_in, mdr_in, mar_in, pc_in, ir_in,
        output hi_out, lo_out, zhigh_out, zlow_out, mdr_out, pc_out, inc_pc, mdatain, opcode
    );

    modport slave (
        input read, r_in, r_out, hi_in, lo_in, y_in, z_in, mdr_in, mar_in, pc_in, ir_in,
        input hi_out, lo_out, zhigh_out, zlow_out, mdr_out, pc_out, inc_pc, mdatain, opcode
    );

endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result destined for Z.
// Latency: zero (purely combinational).
// Backpressure: none.
module alu
    import data_path_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  opcode,
    input  logic        inc_pc,
    output logic [63:0] result
);

    logic [4:0]         sh;
    logic [63:0]        a_dbl;
    logic [31:0]        rot_r;
    logic [31:0]        rot_l;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] sra;
    logic signed [31:0] quo;
    logic signed [31:0] rem;
    logic signed [63:0] a_w;
    logic signed [63:0] b_w;
    logic signed [63:0] prod;

    assign sh    = b[4:0];
    // Rotates are taken from a window over A concatenated with itself;
    // rol by n is ror by 32-n, and n = 0 selects the upper copy unchanged.
    assign a_dbl = {a, a};
    assign rot_r = 32'(a_dbl >> sh);
    assign rot_l = 32'(a_dbl >> (6'd32 - {1'b0, sh}));
    assign a_s   = a;
    assign b_s   = b;
    assign sra   = a_s >>> sh;
    assign a_w   = {{32{a[31]}}, a};
    assign b_w   = {{32{b[31]}}, b};
    assign prod  = a_w * b_w;

    // Signed divide; zero divisor gives zero, and -2^31 / -1 wraps to -2^31 rem 0
    always_comb begin
        quo = '0;
        rem = '0;
        if (b == 32'd0) begin
            quo = '0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quo = a_s;
        end else begin
            quo = a_s / b_s;
            rem = a_s % b_s;
        end
    end

    // Operation select; IncPC overrides opcode, unknown opcodes give zero
    always_comb begin
        result = '0;
        if (inc_pc) begin
            result = {32'd0, b + 32'd1};
        end else begin
            case (opcode)
                OP_ADD:  result = {32'd0, a + b};
                OP_SUB:  result = {32'd0, a - b};
                OP_AND:  result = {32'd0, a & b};
                OP_OR:   result = {32'd0, a | b};
                OP_ROR:  result = {32'd0, rot_r};
                OP_ROL:  result = {32'd0, rot_l};
                OP_SHR:  result = {32'd0, a >> sh};
                OP_SHRA: result = {32'd0, sra};
                OP_SHL:  result = {32'd0, a << sh};
                OP_DIV:  result = {rem, quo};
                OP_MUL:  result = prod;
                OP_NEG:  result = {32'd0, 32'd0 - b};
                OP_NOT:  result = {32'd0, ~b};
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_path_register32.sv
// 32-bit register with load enable and synchronous clear, captured on the falling clock edge.
// Latency: d appears on q after the falling edge where en is high.
// Backpressure: none; clear has priority over en.
module register32 (
    input  logic        clock,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] q_q;
    logic [31:0] q_d;

    // Hold the current value unless a load is requested
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // Falling-edge capture so strobes set at the rising edge have settled
    always_ff @(negedge clock) begin
        if (clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/data_path.sv
// Phase-1 single-bus datapath: register file, special registers, shared bus and ALU.
// Latency: a bus transfer lands in its destination at the falling edge of the same cycle.
// Backpressure: none; all strobes are one-hot-ish commands, overlapping drivers resolved by priority.
module data_path
    import data_path_pkg::*;
(
    input  logic      clock,
    input  logic      clear,
    data_path_if.slave ctl
);

    logic [15:0][31:0] r_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       y_q;
    logic [31:0]       mdr_q;
    logic [31:0]       mar_q;
    logic [31:0]       pc_q;
    logic [31:0]       ir_q;
    logic [63:0]       z_q;
    logic [63:0]       alu_res;
    logic [31:0]       bus;
    logic [31:0]       mdr_d;
    bus_sel_t          bus_sel;

    // Resolve the bus driver; later assignments are higher priority, R0 is highest
    always_comb begin
        bus_sel.src = SRC_NONE;
        bus_sel.gpr = '0;
        if (ctl.pc_out)    bus_sel.src = SRC_PC;
        if (ctl.mdr_out)   bus_sel.src = SRC_MDR;
        if (ctl.zlow_out)  bus_sel.src = SRC_ZLO;
        if (ctl.zhigh_out) bus_sel.src = SRC_ZHI;
        if (ctl.lo_out)    bus_sel.src = SRC_LO;
        if (ctl.hi_out)    bus_sel.src = SRC_HI;
        for (int i = NUM_GPR - 1; i >= 0; i--) begin
            if (ctl.r_out[i]) begin
                bus_sel.src = SRC_GPR;
                bus_sel.gpr = 4'(i);
            end
        end
    end

    // Shared bus mux; floats to zero when nobody drives
    always_comb begin
        bus = '0;
        case (bus_sel.src)
            SRC_GPR: bus = r_q[bus_sel.gpr];
            SRC_HI:  bus = hi_q;
            SRC_LO:  bus = lo_q;
            SRC_ZHI: bus = z_q[63:32];
            SRC_ZLO: bus = z_q[31:0];
            SRC_MDR: bus = mdr_q;
            SRC_PC:  bus = pc_q;
            default: bus = '0;
        endcase
    end

    // MDR loads memory data on a read, otherwise the bus
    always_comb begin
        mdr_d = bus;
        if (ctl.read) begin
            mdr_d = ctl.mdatain;
        end
    end

    for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
        register32 u_r (.clock(clock), .clear(clear), .en(ctl.r_in[g]), .d(bus), .q(r_q[g]));
    end

    register32 u_hi  (.clock(clock), .clear(clear), .en(ctl.hi_in),  .d(bus),   .q(hi_q));
    register32 u_lo  (.clock(clock), .clear(clear), .en(ctl.lo_in),  .d(bus),   .q(lo_q));
    register32 u_y   (.clock(clock), .clear(clear), .en(ctl.y_in),   .d(bus),   .q(y_q));
    register32 u_mdr (.clock(clock), .clear(clear), .en(ctl.mdr_in), .d(mdr_d), .q(mdr_q));
    register32 u_mar (.clock(clock), .clear(clear), .en(ctl.mar_in), .d(bus),   .q(mar_q));
    register32 u_pc  (.clock(clock), .clear(clear), .en(ctl.pc_in),  .d(bus),   .q(pc_q));
    register32 u_ir  (.clock(clock), .clear(clear), .en(ctl.ir_in),  .d(bus),   .q(ir_q));

    // Z is held as two halves so Zhigh and Zlow can drive the bus independently
    register32 u_z_hi (.clock(clock), .clear(clear), .en(ctl.z_in), .d(alu_res[63:32]), .q(z_q[63:32]));
    register32 u_z_lo (.clock(clock), .clear(clear), .en(ctl.z_in), .d(alu_res[31:0]),  .q(z_q[31:0]));

    alu u_alu (
        .a      (y_q),
        .b      (bus),
        .opcode (ctl.opcode),
        .inc_pc (ctl.inc_pc),
        .result (alu_res)
    );

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed transfer sequences plus randomized strobes against a reference model.
// Latency: each stimulus cycle is checked 1 ns after the capturing falling edge.
// Backpressure: n/a.
module tb_data_path;
    import data_path_pkg::*;

    localparam int NREG = 24;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   total = 0;
    int   bad   = 0;

    data_path_if ifc ();

    data_path dut (
        .clock (clock),
        .clear (clear),
        .ctl   (ifc)
    );

    always #10 clock = ~clock;

    // Reference state
    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_y, m_mdr, m_mar, m_pc, m_ir;
    logic [63:0] m_z;

    logic [4:0] ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
                             OP_SHRA, OP_SHL, OP_DIV, OP_MUL, OP_NEG, OP_NOT};

    task automatic idle();
        ifc.read = 1'b0;   ifc.r_in = '0;     ifc.r_out = '0;
        ifc.hi_in = 1'b0;  ifc.lo_in = 1'b0;  ifc.y_in = 1'b0;   ifc.z_in = 1'b0;
        ifc.mdr_in = 1'b0; ifc.mar_in = 1'b0; ifc.pc_in = 1'b0;  ifc.ir_in = 1'b0;
        ifc.hi_out = 1'b0; ifc.lo_out = 1'b0; ifc.zhigh_out = 1'b0; ifc.zlow_out = 1'b0;
        ifc.mdr_out = 1'b0; ifc.pc_out = 1'b0; ifc.inc_pc = 1'b0;
        ifc.mdatain = '0;  ifc.opcode = '0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_hi = '0; m_lo = '0; m_y = '0; m_mdr = '0; m_mar = '0; m_pc = '0; m_ir = '0; m_z = '0;
    endtask

    // Bus value: first asserted source in R0..R15, HI, LO, Zhigh, Zlow, MDR, PC order
    function automatic logic [31:0] model_bus();
        logic [31:0] v;
        logic        found;
        v = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && ifc.r_out[i]) begin v = m_r[i]; found = 1'b1; end
        end
        if (!found && ifc.hi_out)    begin v = m_hi;        found = 1'b1; end
        if (!found && ifc.lo_out)    begin v = m_lo;        found = 1'b1; end
        if (!found && ifc.zhigh_out) begin v = m_z[63:32];  found = 1'b1; end
        if (!found && ifc.zlow_out)  begin v = m_z[31:0];   found = 1'b1; end
        if (!found && ifc.mdr_out)   begin v = m_mdr;       found = 1'b1; end
        if (!found && ifc.pc_out)    begin v = m_pc;        found = 1'b1; end
        return v;
    endfunction

    function automatic logic [63:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [4:0] op, logic inc);
        logic [63:0] r;
        logic [31:0] t;
        int          n, sa, sb;
        longint      p;
        n  = int'(b[4:0]);
        sa = a;
        sb = b;
        t  = a;
        r  = '0;
        if (inc) begin
            r = {32'd0, b + 32'd1};
        end else begin
            case (op)
                5'b00011: r = {32'd0, a + b};
                5'b00100: r = {32'd0, a - b};
                5'b00101: r = {32'd0, a & b};
                5'b00110: r = {32'd0, a | b};
                5'b00111: begin
                    for (int k = 0; k < n; k++) t = {t[0], t[31:1]};
                    r = {32'd0, t};
                end
                5'b01000: begin
                    for (int k = 0; k < n; k++) t = {t[30:0], t[31]};
                    r = {32'd0, t};
                end
                5'b01001: r = {32'd0, a >> n};
                5'b01010: begin
                    for (int k = 0; k < n; k++) t = {t[31], t[31:1]};
                    r = {32'd0, t};
                end
                5'b01011: r = {32'd0, a << n};
                5'b01111: begin
                    if (sb == 0)                              r = '0;
                    else if (a == 32'h8000_0000 && sb == -1)  r = {32'd0, 32'h8000_0000};
                    else                                      r = {32'(sa % sb), 32'(sa / sb)};
                end
                5'b10000: begin
                    p = longint'(sa) * longint'(sb);
                    r = p;
                end
                5'b10001: r = {32'd0, 32'd0 - b};
                5'b10010: r = {32'd0, ~b};
                default:  r = '0;
            endcase
        end
        return r;
    endfunction

    // One clock: predict, let the falling edge capture, update the model, return to idle
    task automatic cycle();
        logic [31:0] b, md;
        logic [63:0] res;
        logic        clr;
        b   = model_bus();
        res = alu_ref(m_y, b, ifc.opcode, ifc.inc_pc);
        md  = ifc.read ? ifc.mdatain : b;
        clr = clear;
        @(negedge clock);
        if (clr) begin
            model_zero();
        end else begin
            for (int i = 0; i < 16; i++) if (ifc.r_in[i]) m_r[i] = b;
            if (ifc.hi_in)  m_hi  = b;
            if (ifc.lo_in)  m_lo  = b;
            if (ifc.y_in)   m_y   = b;
            if (ifc.mdr_in) m_mdr = md;
            if (ifc.mar_in) m_mar = b;
            if (ifc.pc_in)  m_pc  = b;
            if (ifc.ir_in)  m_ir  = b;
            if (ifc.z_in)   m_z   = res;
        end
        #1;
        idle();
        clear = 1'b0;
    endtask

    function automatic logic [63:0] dut_reg(int k);
        logic [63:0] v;
        v = '0;
        if (k < 16) v = {32'd0, dut.r_q[k]};
        else case (k)
            16: v = {32'd0, dut.hi_q};
            17: v = {32'd0, dut.lo_q};
            18: v = {32'd0, dut.y_q};
            19: v = {32'd0, dut.mdr_q};
            20: v = {32'd0, dut.mar_q};
            21: v = {32'd0, dut.pc_q};
            22: v = {32'd0, dut.ir_q};
            default: v = dut.z_q;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] mdl_reg(int k);
        logic [63:0] v;
        v = '0;
        if (k < 16) v = {32'd0, m_r[k]};
        else case (k)
            16: v = {32'd0, m_hi};
            17: v = {32'd0, m_lo};
            18: v = {32'd0, m_y};
            19: v = {32'd0, m_mdr};
            20: v = {32'd0, m_mar};
            21: v = {32'd0, m_pc};
            22: v = {32'd0, m_ir};
            default: v = m_z;
        endcase
        return v;
    endfunction

    task automatic set_out(int s);
        if (s < 16) ifc.r_out[s] = 1'b1;
        else case (s)
            16: ifc.hi_out    = 1'b1;
            17: ifc.lo_out    = 1'b1;
            18: ifc.zhigh_out = 1'b1;
            19: ifc.zlow_out  = 1'b1;
            20: ifc.mdr_out   = 1'b1;
            default: ifc.pc_out = 1'b1;
        endcase
    endtask

    task automatic load_mdr(input logic [31:0] v);
        ifc.read = 1'b1; ifc.mdr_in = 1'b1; ifc.mdatain = v;
        cycle();
    endtask

    task automatic mdr_to_r(input int k);
        ifc.mdr_out = 1'b1; ifc.r_in[k] = 1'b1;
        cycle();
    endtask

    task automatic mdr_to_y();
        ifc.mdr_out = 1'b1; ifc.y_in = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        clear = 1'b1; cycle();
        clear = 1'b1; cycle();
        for (int k = 0; k < NREG; k++) begin
            total++;
            if (dut_reg(k) !== 64'd0) begin
                bad++;
                $display("FAIL reset reg%0d: got %h want 0", k, dut_reg(k));
            end
        end
    endtask

    task automatic test_reg_load();
        logic [31:0] vals [3] = '{32'h0000_F00D, 32'h0000_ABCD, 32'h0000_0001};
        int          dst  [3] = '{3, 7, 4};
        for (int i = 0; i < 3; i++) begin
            load_mdr(vals[i]);
            mdr_to_r(dst[i]);
            total++;
            if (dut.r_q[dst[i]] !== vals[i]) begin
                bad++;
                $display("FAIL reg_load R%0d: got %h want %h", dst[i], dut.r_q[dst[i]], vals[i]);
            end
        end
    endtask

    task automatic test_fetch();
        ifc.pc_out = 1'b1; ifc.mar_in = 1'b1; ifc.inc_pc = 1'b1; ifc.z_in = 1'b1;
        cycle();
        total++;
        if (dut.mar_q !== 32'd0) begin bad++; $display("FAIL fetch MAR: got %h want 0", dut.mar_q); end
        total++;
        if (dut.z_q !== 64'd1) begin bad++; $display("FAIL fetch Z: got %h want 1", dut.z_q); end
        ifc.zlow_out = 1'b1; ifc.pc_in = 1'b1; ifc.read = 1'b1; ifc.mdr_in = 1'b1;
        ifc.mdatain = 32'h2A2B_8000;
        cycle();
        total++;
        if (dut.pc_q !== 32'd1) begin bad++; $display("FAIL fetch PC: got %h want 1", dut.pc_q); end
        total++;
        if (dut.mdr_q !== 32'h2A2B_8000) begin
            bad++; $display("FAIL fetch MDR: got %h want 2a2b8000", dut.mdr_q);
        end
        ifc.mdr_out = 1'b1; ifc.ir_in = 1'b1;
        cycle();
        total++;
        if (dut.ir_q !== 32'h2A2B_8000) begin
            bad++; $display("FAIL fetch IR: got %h want 2a2b8000", dut.ir_q);
        end
    endtask

    task automatic test_logic_arith();
        logic [4:0]  op  [4] = '{OP_AND, OP_OR, OP_ADD, OP_SUB};
        logic [31:0] exp [4] = '{32'h0000_A00D, 32'h0000_FBCD, 32'h0001_9BDA, 32'h0000_4440};
        ifc.r_out[3] = 1'b1; ifc.y_in = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            ifc.r_out[7] = 1'b1; ifc.opcode = op[i]; ifc.z_in = 1'b1;
            cycle();
            total++;
            if (dut.z_q !== {32'd0, exp[i]}) begin
                bad++; $display("FAIL alu op%b Z: got %h want %h", op[i], dut.z_q, {32'd0, exp[i]});
            end
            if (i == 0) begin
                ifc.zlow_out = 1'b1; ifc.r_in[4] = 1'b1;
                cycle();
                total++;
                if (dut.r_q[4] !== 32'h0000_A00D) begin
                    bad++; $display("FAIL and R4: got %h want 0000a00d", dut.r_q[4]);
                end
            end
        end
    endtask

    task automatic test_mul_div();
        load_mdr(32'hFFFF_FFFE); mdr_to_y(); load_mdr(32'd3);
        ifc.mdr_out = 1'b1; ifc.opcode = OP_MUL; ifc.z_in = 1'b1;
        cycle();
        total++;
        if (dut.z_q !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            bad++; $display("FAIL mul Z: got %h want fffffffffffffffa", dut.z_q);
        end
        load_mdr(32'd7); mdr_to_y(); load_mdr(32'd2);
        ifc.mdr_out = 1'b1; ifc.opcode = OP_DIV; ifc.z_in = 1'b1;
        cycle();
        total++;
        if (dut.z_q !== 64'h0000_0001_0000_0003) begin
            bad++; $display("FAIL div Z: got %h want 0000000100000003", dut.z_q);
        end
        // No bus driver leaves the bus at zero: divide by zero
        ifc.opcode = OP_DIV; ifc.z_in = 1'b1;
        cycle();
        total++;
        if (dut.z_q !== 64'd0) begin bad++; $display("FAIL div0 Z: got %h want 0", dut.z_q); end
    endtask

    task automatic test_priority();
        load_mdr(32'h1111_1111); mdr_to_r(1); load_mdr(32'h2222_2222);
        ifc.r_out[1] = 1'b1; ifc.pc_out = 1'b1; ifc.mdr_out = 1'b1; ifc.r_in[9] = 1'b1;
        cycle();
        total++;
        if (dut.r_q[9] !== 32'h1111_1111) begin
            bad++; $display("FAIL prio R9: got %h want 11111111", dut.r_q[9]);
        end
        ifc.mdr_out = 1'b1; ifc.pc_out = 1'b1; ifc.r_in[10] = 1'b1;
        cycle();
        total++;
        if (dut.r_q[10] !== 32'h2222_2222) begin
            bad++; $display("FAIL prio R10: got %h want 22222222", dut.r_q[10]);
        end
        ifc.r_out[9] = 1'b1; ifc.r_in[9] = 1'b1; ifc.mdr_out = 1'b1;
        cycle();
        total++;
        if (dut.r_q[9] !== 32'h1111_1111) begin
            bad++; $display("FAIL self_load R9: got %h want 11111111", dut.r_q[9]);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        ifc.r_in[3] = 1'b1; ifc.mdr_out = 1'b1; ifc.z_in = 1'b1; ifc.pc_in = 1'b1;
        ifc.opcode = OP_ADD;
        cycle();
        for (int k = 0; k < NREG; k++) begin
            total++;
            if (dut_reg(k) !== 64'd0) begin
                bad++; $display("FAIL clear reg%0d: got %h want 0", k, dut_reg(k));
            end
        end
    endtask

    task automatic test_random();
        int nout;
        for (int n = 0; n < 400; n++) begin
            ifc.r_in   = 16'($urandom) & 16'($urandom);
            ifc.hi_in  = ($urandom_range(0, 3) == 0);
            ifc.lo_in  = ($urandom_range(0, 3) == 0);
            ifc.y_in   = ($urandom_range(0, 2) == 0);
            ifc.z_in   = ($urandom_range(0, 1) == 0);
            ifc.mdr_in = ($urandom_range(0, 2) == 0);
            ifc.mar_in = ($urandom_range(0, 3) == 0);
            ifc.pc_in  = ($urandom_range(0, 3) == 0);
            ifc.ir_in  = ($urandom_range(0, 3) == 0);
            nout = $urandom_range(0, 2);
            for (int j = 0; j < nout; j++) set_out(int'($urandom_range(0, 21)));
            ifc.opcode  = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 12)]
                                                      : 5'($urandom_range(0, 31));
            ifc.inc_pc  = ($urandom_range(0, 7) == 0);
            ifc.read    = 1'($urandom_range(0, 1));
            ifc.mdatain = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            clear       = ($urandom_range(0, 49) == 0);
            cycle();
            for (int k = 0; k < NREG; k++) begin
                total++;
                if (dut_reg(k) !== mdl_reg(k)) begin
                    bad++;
                    $display("FAIL random step%0d reg%0d: got %h want %h", n, k, dut_reg(k), mdl_reg(k));
                end
            end
        end
    endtask

    initial begin
        idle();
        model_zero();
        test_reset();
        test_reg_load();
        test_fetch();
        test_logic_arith();
        test_mul_div();
        test_priority();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
